rename_map_ckpt: RTL and testbench

RENAME_MAP_CKPT -- requirements
Module: rename_map_ckpt

---
 rtl/sys_defs.sv | 20 ++
 rtl/map_ckpt_fifo.sv | 89 ++++++++
 rtl/rename_map_ckpt.sv | 134 +++++++++++++
 tb/tb_rename_map_ckpt.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared rename-stage definitions: parameter defaults, map-table entry and CDB packet types.
package sys_defs;

    localparam int WAY_DEF   = 3;
    localparam int CDB_W_DEF = 3;
    localparam int NCKPT_DEF = 4;
    localparam int PR_W_DEF  = 6;
    localparam int NUM_AR    = 32;

    typedef struct packed {
        logic [PR_W_DEF-1:0] tag;
        logic                ready;
    } map_entry_t;

    typedef struct packed {
        logic                valid;
        logic [PR_W_DEF-1:0] tag;
    } cdb_pkt_t;

endpackage

// File: rtl/map_ckpt_fifo.sv
// Circular FIFO of map-table snapshots, one per unresolved branch.
module map_ckpt_fifo
    import sys_defs::*;
#(
    parameter  int NCKPT = NCKPT_DEF,
    parameter  int CDB_W = CDB_W_DEF,
    localparam int CK_W  = $clog2(NCKPT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  map_entry_t            push_data [NUM_AR],
    input  logic                  commit,
    input  logic                  restore,
    input  logic [CK_W-1:0]       restore_id,
    input  cdb_pkt_t [CDB_W-1:0]  cdb,
    output map_entry_t            rd_data [NUM_AR],
    output logic                  restore_ok,
    output logic [CK_W-1:0]       tail_id,
    output logic [CK_W:0]         count,
    output logic                  full
);

    map_entry_t      mem [NCKPT][NUM_AR];
    logic [CK_W-1:0] head_q, tail_q, head_c, head_n, tail_n, rel;
    logic [CK_W:0]   count_q, count_c, count_n;
    logic            full_q, do_commit, do_push;

    function automatic logic cdb_hit(input logic [PR_W_DEF-1:0] t);
        cdb_hit = 1'b0;
        for (int unsigned c = 0; c < CDB_W; c++)
            if (cdb[c].valid && cdb[c].tag == t) cdb_hit = 1'b1;
    endfunction

    // Commit retires the head first, so liveness of restore_id is judged post-commit.
    always_comb begin
        do_commit  = commit && (count_q != '0);
        head_c     = head_q + CK_W'(do_commit);
        count_c    = count_q - (CK_W+1)'(do_commit);
        rel        = restore_id - head_c;
        restore_ok = restore && ({1'b0, rel} < count_c);
        do_push    = push && !clear && !restore_ok;
        head_n     = head_c;
        tail_n     = tail_q;
        count_n    = count_c;
        if (clear) begin
            head_n  = '0;
            tail_n  = '0;
            count_n = '0;
        end else if (restore_ok) begin
            tail_n  = restore_id;
            count_n = {1'b0, rel};
        end else if (do_push) begin
            tail_n  = tail_q + CK_W'(1);
            count_n = count_c + (CK_W+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= count_n;
            full_q  <= (count_n == (CK_W+1)'(NCKPT));
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned k = 0; k < NCKPT; k++)
            for (int unsigned a = 0; a < NUM_AR; a++)
                if (do_push && tail_q == CK_W'(k)) mem[k][a] <= push_data[a];
                else if (cdb_hit(mem[k][a].tag)) mem[k][a].ready <= 1'b1;
    end

    always_comb begin
        for (int unsigned a = 0; a < NUM_AR; a++) rd_data[a] = mem[restore_id][a];
    end

    assign tail_id = tail_q;
    assign count   = count_q;
    assign full    = full_q;

endmodule

// File: rtl/rename_map_ckpt.sv
// Register rename map with intra-group bypass, CDB wakeup and branch checkpoints.
// PR_W must equal sys_defs::PR_W_DEF because map entries are package types.
module rename_map_ckpt
    import sys_defs::*;
#(
    parameter  int WAY    = WAY_DEF,
    parameter  int CDB_W  = CDB_W_DEF,
    parameter  int NCKPT  = NCKPT_DEF,
    parameter  int PR_W   = PR_W_DEF,
    localparam int CK_W   = $clog2(NCKPT),
    localparam int SLOT_W = (WAY > 1) ? $clog2(WAY) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WAY-1:0]             rn_valid,
    input  logic [WAY-1:0][4:0]        rn_dest_ar,
    input  logic [WAY-1:0][PR_W-1:0]   rn_new_pr,
    input  logic [WAY-1:0][4:0]        rn_src1_ar,
    input  logic [WAY-1:0][4:0]        rn_src2_ar,
    output logic [WAY-1:0][PR_W-1:0]   src1_tag,
    output logic [WAY-1:0][PR_W-1:0]   src2_tag,
    output logic [WAY-1:0]             src1_ready,
    output logic [WAY-1:0]             src2_ready,
    output logic [WAY-1:0][PR_W-1:0]   told,
    input  logic [CDB_W-1:0]           cdb_valid,
    input  logic [CDB_W-1:0][PR_W-1:0] cdb_tag,
    input  logic                       ck_req,
    input  logic [SLOT_W-1:0]          ck_slot,
    output logic [CK_W-1:0]            ck_id,
    output logic                       ck_full,
    output logic [CK_W:0]              ck_count,
    input  logic                       ck_commit,
    input  logic                       ck_restore,
    input  logic [CK_W-1:0]            ck_restore_id,
    input  logic                       arch_recover,
    input  logic [31:0][PR_W-1:0]      arch_map
);

    map_entry_t           table_q  [NUM_AR];
    map_entry_t           cdb_tab  [NUM_AR];
    map_entry_t           ren_tab  [NUM_AR];
    map_entry_t           snap_tab [NUM_AR];
    map_entry_t           snap_rd  [NUM_AR];
    map_entry_t           next_tab [NUM_AR];
    map_entry_t           s1_e [WAY];
    map_entry_t           s2_e [WAY];
    map_entry_t           td_e [WAY];
    cdb_pkt_t [CDB_W-1:0] cdb;
    logic                 stall, push, restore_ok;

    always_comb begin
        for (int unsigned c = 0; c < CDB_W; c++) cdb[c] = '{valid: cdb_valid[c], tag: cdb_tag[c]};
    end

    assign stall = ck_req && ck_full;
    assign push  = ck_req && !ck_full;

    function automatic logic cdb_hit(input logic [PR_W-1:0] t);
        cdb_hit = 1'b0;
        for (int unsigned c = 0; c < CDB_W; c++)
            if (cdb[c].valid && cdb[c].tag == t) cdb_hit = 1'b1;
    endfunction

    // Later matching slots overwrite earlier ones, so the youngest older producer wins.
    function automatic map_entry_t resolve(input logic [4:0] ar, input int unsigned slot);
        resolve       = table_q[ar];
        resolve.ready = resolve.ready | cdb_hit(resolve.tag);
        for (int unsigned j = 0; j < slot; j++)
            if (rn_valid[j] && rn_dest_ar[j] == ar) resolve = '{tag: rn_new_pr[j], ready: 1'b0};
        if (ar == '0) resolve = '{tag: '0, ready: 1'b1};
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < WAY; i++) begin
            s1_e[i]       = resolve(rn_src1_ar[i], i);
            s2_e[i]       = resolve(rn_src2_ar[i], i);
            td_e[i]       = resolve(rn_dest_ar[i], i);
            src1_tag[i]   = s1_e[i].tag;
            src1_ready[i] = s1_e[i].ready;
            src2_tag[i]   = s2_e[i].tag;
            src2_ready[i] = s2_e[i].ready;
            told[i]       = td_e[i].tag;
        end
    end

    // CDB wakeup is applied before rename writes so a same-cycle rename keeps ready=0.
    always_comb begin
        for (int unsigned a = 0; a < NUM_AR; a++) begin
            cdb_tab[a] = table_q[a];
            if (cdb_hit(table_q[a].tag)) cdb_tab[a].ready = 1'b1;
        end
        ren_tab  = cdb_tab;
        snap_tab = cdb_tab;
        for (int unsigned i = 0; i < WAY; i++) begin
            if (rn_valid[i] && !stall && rn_dest_ar[i] != '0) begin
                ren_tab[rn_dest_ar[i]] = '{tag: rn_new_pr[i], ready: 1'b0};
                if (i <= 32'(ck_slot)) snap_tab[rn_dest_ar[i]] = '{tag: rn_new_pr[i], ready: 1'b0};
            end
        end
        for (int unsigned a = 0; a < NUM_AR; a++) begin
            next_tab[a] = ren_tab[a];
            if (arch_recover)
                next_tab[a] = '{tag: arch_map[a], ready: 1'b1};
            else if (restore_ok)
                next_tab[a] = '{tag: snap_rd[a].tag, ready: snap_rd[a].ready | cdb_hit(snap_rd[a].tag)};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned a = 0; a < NUM_AR; a++) table_q[a] <= '{tag: PR_W'(a), ready: 1'b1};
        end else begin
            table_q <= next_tab;
        end
    end

    map_ckpt_fifo #(.NCKPT(NCKPT), .CDB_W(CDB_W)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .clear      (arch_recover),
        .push       (push),
        .push_data  (snap_tab),
        .commit     (ck_commit),
        .restore    (ck_restore),
        .restore_id (ck_restore_id),
        .cdb        (cdb),
        .rd_data    (snap_rd),
        .restore_ok (restore_ok),
        .tail_id    (ck_id),
        .count      (ck_count),
        .full       (ck_full)
    );

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Directed bench for rename_map_ckpt: table-driven rename/bypass/CDB vectors plus checkpoint sequences.
module tb_rename_map_ckpt;

    localparam int WAY = 3, CDB_W = 3, NCKPT = 4, PR_W = 6;

    logic                       clock, reset;
    logic [WAY-1:0]             rn_valid;
    logic [WAY-1:0][4:0]        rn_dest_ar, rn_src1_ar, rn_src2_ar;
    logic [WAY-1:0][PR_W-1:0]   rn_new_pr, src1_tag, src2_tag, told;
    logic [WAY-1:0]             src1_ready, src2_ready;
    logic [CDB_W-1:0]           cdb_valid;
    logic [CDB_W-1:0][PR_W-1:0] cdb_tag;
    logic                       ck_req, ck_full, ck_commit, ck_restore, arch_recover;
    logic [1:0]                 ck_slot, ck_id, ck_restore_id;
    logic [2:0]                 ck_count;
    logic [31:0][PR_W-1:0]      arch_map;

    int checks = 0;
    int errors = 0;

    rename_map_ckpt #(.WAY(WAY), .CDB_W(CDB_W), .NCKPT(NCKPT), .PR_W(PR_W)) dut (
        .clock(clock), .reset(reset),
        .rn_valid(rn_valid), .rn_dest_ar(rn_dest_ar), .rn_new_pr(rn_new_pr),
        .rn_src1_ar(rn_src1_ar), .rn_src2_ar(rn_src2_ar),
        .src1_tag(src1_tag), .src2_tag(src2_tag),
        .src1_ready(src1_ready), .src2_ready(src2_ready), .told(told),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .ck_req(ck_req), .ck_slot(ck_slot), .ck_id(ck_id), .ck_full(ck_full),
        .ck_count(ck_count), .ck_commit(ck_commit), .ck_restore(ck_restore),
        .ck_restore_id(ck_restore_id), .arch_recover(arch_recover), .arch_map(arch_map)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] v;
        int d[3];
        int p[3];
        int cs, s1, s2;
        logic [2:0] cv;
        int ct;
        int e1t, e1r, e2t, e2r, et;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [2:0] v, input int d0, p0, d1, p1, d2, p2,
                                input int cs, s1, s2, input logic [2:0] cv, input int ct,
                                input int e1t, e1r, e2t, e2r, et);
        mk.v = v;
        mk.d[0] = d0; mk.d[1] = d1; mk.d[2] = d2;
        mk.p[0] = p0; mk.p[1] = p1; mk.p[2] = p2;
        mk.cs = cs; mk.s1 = s1; mk.s2 = s2;
        mk.cv = cv; mk.ct = ct;
        mk.e1t = e1t; mk.e1r = e1r; mk.e2t = e2t; mk.e2r = e2r; mk.et = et;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clr();
        rn_valid = '0; rn_dest_ar = '0; rn_new_pr = '0;
        rn_src1_ar = '0; rn_src2_ar = '0;
        cdb_valid = '0; cdb_tag = '0;
        ck_req = 1'b0; ck_slot = '0; ck_commit = 1'b0;
        ck_restore = 1'b0; ck_restore_id = '0;
        arch_recover = 1'b0; arch_map = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic probe(input int a1, input int a2);
        rn_src1_ar[0] = 5'(a1);
        rn_src2_ar[0] = 5'(a2);
        #1;
    endtask

    initial begin
        // mk(v, d0,p0, d1,p1, d2,p2, cs, s1,s2, cv,ct, e1t,e1r, e2t,e2r, told)
        vecs[0]  = mk(3'b011, 1,10, 0,11, 0,0,  1, 1,2,  3'b000,0,  10,0, 2,1,  0);
        vecs[1]  = mk(3'b000, 3,0,  0,0,  0,0,  0, 1,0,  3'b000,0,  10,0, 0,1,  3);
        vecs[2]  = mk(3'b011, 3,20, 3,21, 0,0,  1, 3,4,  3'b000,0,  20,0, 4,1,  20);
        vecs[3]  = mk(3'b001, 0,40, 0,0,  0,0,  0, 3,0,  3'b000,0,  21,0, 0,1,  0);
        vecs[4]  = mk(3'b000, 0,0,  0,0,  5,0,  2, 0,3,  3'b000,0,  0,1,  21,0, 5);
        vecs[5]  = mk(3'b000, 1,0,  0,0,  0,0,  0, 1,3,  3'b001,10, 10,1, 21,0, 10);
        vecs[6]  = mk(3'b000, 6,0,  0,0,  0,0,  0, 1,2,  3'b000,0,  10,1, 2,1,  6);
        vecs[7]  = mk(3'b001, 3,22, 7,0,  0,0,  1, 3,1,  3'b100,22, 22,0, 10,1, 7);
        vecs[8]  = mk(3'b000, 3,0,  0,0,  0,0,  0, 3,9,  3'b000,0,  22,0, 9,1,  22);
        vecs[9]  = mk(3'b100, 1,50, 1,0,  8,51, 1, 1,2,  3'b000,0,  10,1, 2,1,  10);
        vecs[10] = mk(3'b000, 8,0,  0,0,  0,0,  0, 8,1,  3'b000,0,  51,0, 10,1, 51);
        vecs[11] = mk(3'b111, 9,52, 9,53, 10,54, 2, 9,8, 3'b000,0,  53,0, 51,0, 10);
        vecs[12] = mk(3'b000, 9,0,  0,0,  0,0,  0, 9,10, 3'b000,0,  53,0, 54,0, 53);

        clr();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        probe(5, 0);
        chk("reset x5 tag", src1_tag[0], 5);
        chk("reset x5 ready", src1_ready[0], 1);
        chk("reset x0 tag", src2_tag[0], 0);
        chk("reset count", ck_count, 0);
        chk("reset full", ck_full, 0);
        chk("reset ck_id", ck_id, 0);

        for (int n = 0; n < 13; n++) begin
            clr();
            rn_valid = vecs[n].v;
            for (int s = 0; s < WAY; s++) begin
                rn_dest_ar[s] = 5'(vecs[n].d[s]);
                rn_new_pr[s]  = 6'(vecs[n].p[s]);
                cdb_tag[s]    = 6'(vecs[n].ct);
            end
            rn_src1_ar[vecs[n].cs] = 5'(vecs[n].s1);
            rn_src2_ar[vecs[n].cs] = 5'(vecs[n].s2);
            cdb_valid = vecs[n].cv;
            #1;
            chk($sformatf("v%0d src1_tag", n),   src1_tag[vecs[n].cs],   vecs[n].e1t);
            chk($sformatf("v%0d src1_ready", n), src1_ready[vecs[n].cs], vecs[n].e1r);
            chk($sformatf("v%0d src2_tag", n),   src2_tag[vecs[n].cs],   vecs[n].e2t);
            chk($sformatf("v%0d src2_ready", n), src2_ready[vecs[n].cs], vecs[n].e2r);
            chk($sformatf("v%0d told", n),       told[vecs[n].cs],       vecs[n].et);
            chk($sformatf("v%0d count", n),      ck_count,               0);
            tick();
        end

        // Reset with live activity discards the renames from the vectors above.
        clr();
        rn_valid = 3'b001; rn_dest_ar[0] = 5; rn_new_pr[0] = 61; ck_req = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clr();
        probe(5, 1);
        chk("midreset x5 tag", src1_tag[0], 5);
        chk("midreset x1 tag", src2_tag[0], 1);
        chk("midreset x1 ready", src2_ready[0], 1);
        chk("midreset count", ck_count, 0);

        // Checkpoint after slot 0, restore recovers x2=30 with CDB-updated ready.
        clr();
        rn_valid = 3'b011;
        rn_dest_ar[0] = 2; rn_new_pr[0] = 30;
        rn_dest_ar[1] = 2; rn_new_pr[1] = 31;
        ck_req = 1'b1; ck_slot = 0;
        #1;
        chk("A ck_id", ck_id, 0);
        tick();
        clr();
        probe(2, 0);
        chk("A x2 tag", src1_tag[0], 31);
        chk("A count", ck_count, 1);
        cdb_valid = 3'b001; cdb_tag[0] = 30;
        #1;
        chk("A x2 ready cdb30", src1_ready[0], 0);
        tick();
        clr();
        ck_restore = 1'b1; ck_restore_id = 0;
        rn_valid = 3'b001; rn_dest_ar[0] = 2; rn_new_pr[0] = 40; ck_req = 1'b1;
        tick();
        clr();
        probe(2, 0);
        chk("A restored x2 tag", src1_tag[0], 30);
        chk("A restored x2 ready", src1_ready[0], 1);
        chk("A restored count", ck_count, 0);
        chk("A restored ck_id", ck_id, 0);

        // Fill all checkpoints, then stall, commit, wrap.
        for (int k = 0; k < 4; k++) begin
            clr();
            rn_valid = 3'b001; rn_dest_ar[0] = 5'(11 + k); rn_new_pr[0] = 6'(40 + k);
            ck_req = 1'b1;
            #1;
            chk($sformatf("B fill%0d ck_id", k), ck_id, k);
            tick();
        end
        clr();
        #1;
        chk("B count full", ck_count, 4);
        chk("B ck_full", ck_full, 1);
        rn_valid = 3'b001; rn_dest_ar[0] = 15; rn_new_pr[0] = 50; ck_req = 1'b1;
        tick();
        clr();
        probe(15, 0);
        chk("B stalled x15 tag", src1_tag[0], 15);
        chk("B stalled count", ck_count, 4);
        ck_commit = 1'b1;
        tick();
        clr();
        #1;
        chk("B commit count", ck_count, 3);
        chk("B commit full", ck_full, 0);
        ck_req = 1'b1;
        #1;
        chk("B wrap ck_id", ck_id, 0);
        tick();
        clr();
        ck_commit = 1'b1; ck_restore = 1'b1; ck_restore_id = 2;
        tick();
        clr();
        probe(13, 14);
        chk("B cr x13 tag", src1_tag[0], 42);
        chk("B cr x13 ready", src1_ready[0], 0);
        chk("B cr x14 tag", src2_tag[0], 14);
        chk("B cr count", ck_count, 0);
        ck_restore = 1'b1; ck_restore_id = 1;
        rn_valid = 3'b001; rn_dest_ar[0] = 20; rn_new_pr[0] = 60;
        tick();
        clr();
        probe(20, 0);
        chk("B nonlive x20 tag", src1_tag[0], 60);
        chk("B nonlive count", ck_count, 0);
        ck_commit = 1'b1;
        tick();
        clr();
        #1;
        chk("B empty commit count", ck_count, 0);
        chk("B empty commit ck_id", ck_id, 2);

        // arch_recover overrides a simultaneous live restore.
        ck_req = 1'b1;
        tick();
        clr();
        #1;
        chk("C pre count", ck_count, 1);
        arch_recover = 1'b1;
        for (int i = 0; i < 32; i++) arch_map[i] = 6'(i + 32);
        ck_restore = 1'b1; ck_restore_id = 2;
        rn_valid = 3'b001; rn_dest_ar[0] = 3; rn_new_pr[0] = 5;
        tick();
        clr();
        #1;
        chk("C count", ck_count, 0);
        chk("C ck_id", ck_id, 0);
        chk("C full", ck_full, 0);
        for (int a = 0; a < 32; a += 2) begin
            probe(a, a + 1);
            chk($sformatf("C x%0d tag", a), src1_tag[0], (a == 0) ? 0 : a + 32);
            chk($sformatf("C x%0d ready", a), src1_ready[0], 1);
            chk($sformatf("C x%0d tag", a + 1), src2_tag[0], a + 33);
            chk($sformatf("C x%0d ready", a + 1), src2_ready[0], 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
